// File: rtl/coin_pkg.sv
// Shared types and geometry constants for the coin sprite address generator.
package coin_pkg;

   typedef enum logic [1:0] {StHidden, StSpin, StCollect, StGone} coin_state_e;

   localparam int unsigned TILE    = 16;
   localparam int unsigned FRAMES  = 8;
   localparam int unsigned SHEET_W = 128;
   localparam int unsigned X_MAX   = 624;
   localparam int unsigned Y_MAX   = 464;
   localparam int unsigned H_LAST  = 639;
   localparam int unsigned V_LAST  = 479;

   function automatic logic [9:0] clamp10(input logic [9:0] v, input logic [9:0] lim);
      return (v > lim) ? lim : v;
   endfunction

endpackage

// File: rtl/coin_anim_addr_if.sv
// Pixel-scan, control and sprite-address signals between the video pipeline and the coin block.
interface coin_anim_addr_if;

   logic [9:0]  DrawX;
   logic [9:0]  DrawY;
   logic        blank;
   logic        spawn;
   logic [9:0]  spawn_x;
   logic [9:0]  spawn_y;
   logic        collect;
   logic [10:0] rom_address;
   logic        sprite_on;
   logic        blank_d;
   logic        collect_done;

   modport master (
      output DrawX, DrawY, blank, spawn, spawn_x, spawn_y, collect,
      input  rom_address, sprite_on, blank_d, collect_done
   );

   modport slave (
      input  DrawX, DrawY, blank, spawn, spawn_x, spawn_y, collect,
      output rom_address, sprite_on, blank_d, collect_done
   );

endinterface

// File: rtl/coin_frame_tick.sv
// Flags the last visible pixel of a frame; the coin state commits on this pixel.
module coin_frame_tick
   import coin_pkg::*;
(
   input  logic [9:0] draw_x_i,
   input  logic [9:0] draw_y_i,
   output logic       frame_tick_o
);

   assign frame_tick_o = (draw_x_i == 10'(H_LAST)) && (draw_y_i == 10'(V_LAST));

endmodule

// File: rtl/coin_anim_addr.sv
// Coin lifecycle FSM plus registered sprite-sheet address generation for the coin ROM.
module coin_anim_addr
   import coin_pkg::*;
#(
   parameter int unsigned SLOW_DIV      = 6,
   parameter int unsigned COLLECT_TICKS = 16
) (
   input  logic           vga_clk,
   input  logic           reset,
   coin_anim_addr_if.slave bus
);

   localparam int unsigned DivW = (SLOW_DIV > 1) ? $clog2(SLOW_DIV) : 1;
   localparam int unsigned ColW = (COLLECT_TICKS > 1) ? $clog2(COLLECT_TICKS) : 1;
   localparam int unsigned FrmW = $clog2(FRAMES);

   logic frame_tick;

   coin_frame_tick u_frame_tick (
      .draw_x_i     (bus.DrawX),
      .draw_y_i     (bus.DrawY),
      .frame_tick_o (frame_tick)
   );

   coin_state_e     state_q, state_d;
   logic [FrmW-1:0] frame_idx_q, frame_idx_d;
   logic [DivW-1:0] div_cnt_q, div_cnt_d;
   logic [ColW-1:0] collect_cnt_q, collect_cnt_d;
   logic [9:0]      pend_x_q, pend_x_d, pend_y_q, pend_y_d;
   logic [9:0]      px_q, px_d, py_q, py_d;
   logic            draw_en_q, draw_en_d;
   logic            sprite_on_q, sprite_on_d;
   logic [10:0]     rom_address_q, rom_address_d;
   logic            blank_dly_q, blank_dly_d;
   logic            collect_done_q, collect_done_d;

   logic [9:0] dx, dy;
   logic       hit;

   always_comb begin
      state_d        = state_q;
      frame_idx_d    = frame_idx_q;
      div_cnt_d      = div_cnt_q;
      collect_cnt_d  = collect_cnt_q;
      pend_x_d       = pend_x_q;
      pend_y_d       = pend_y_q;
      px_d           = px_q;
      py_d           = py_q;
      draw_en_d      = draw_en_q;
      collect_done_d = 1'b0;

      case (state_q)
         StHidden, StGone: begin
            if (bus.spawn) begin
               state_d     = StSpin;
               frame_idx_d = '0;
               div_cnt_d   = '0;
               pend_x_d    = clamp10(bus.spawn_x, 10'(X_MAX));
               pend_y_d    = clamp10(bus.spawn_y, 10'(Y_MAX));
            end
         end
         StSpin: begin
            if (bus.collect) begin
               state_d       = StCollect;
               collect_cnt_d = '0;
            end else if (frame_tick) begin
               if (div_cnt_q == DivW'(SLOW_DIV - 1)) begin
                  div_cnt_d   = '0;
                  frame_idx_d = frame_idx_q + FrmW'(1);
               end else begin
                  div_cnt_d = div_cnt_q + DivW'(1);
               end
            end
         end
         StCollect: begin
            if (frame_tick) begin
               frame_idx_d   = frame_idx_q + FrmW'(1);
               collect_cnt_d = collect_cnt_q + ColW'(1);
               if (collect_cnt_q == ColW'(COLLECT_TICKS - 1)) begin
                  state_d        = StGone;
                  collect_done_d = 1'b1;
               end
            end
         end
         default: state_d = StHidden;
      endcase

      // Visible position/enable only change between frames so the sprite never tears.
      if (frame_tick) begin
         px_d      = pend_x_d;
         py_d      = pend_y_d;
         draw_en_d = (state_d == StSpin) || (state_d == StCollect);
      end
   end

   assign dx  = bus.DrawX - px_q;
   assign dy  = bus.DrawY - py_q;
   assign hit = bus.blank && draw_en_q &&
                (bus.DrawX >= px_q) && (dx < 10'(TILE)) &&
                (bus.DrawY >= py_q) && (dy < 10'(TILE));

   always_comb begin
      sprite_on_d   = hit;
      rom_address_d = hit ? {dy[3:0], frame_idx_q, dx[3:0]} : '0;
      blank_dly_d   = bus.blank;
   end

   always_ff @(posedge vga_clk) begin
      if (reset) begin
         state_q        <= StHidden;
         frame_idx_q    <= '0;
         div_cnt_q      <= '0;
         collect_cnt_q  <= '0;
         pend_x_q       <= '0;
         pend_y_q       <= '0;
         px_q           <= '0;
         py_q           <= '0;
         draw_en_q      <= 1'b0;
         sprite_on_q    <= 1'b0;
         rom_address_q  <= '0;
         blank_dly_q    <= 1'b0;
         collect_done_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         frame_idx_q    <= frame_idx_d;
         div_cnt_q      <= div_cnt_d;
         collect_cnt_q  <= collect_cnt_d;
         pend_x_q       <= pend_x_d;
         pend_y_q       <= pend_y_d;
         px_q           <= px_d;
         py_q           <= py_d;
         draw_en_q      <= draw_en_d;
         sprite_on_q    <= sprite_on_d;
         rom_address_q  <= rom_address_d;
         blank_dly_q    <= blank_dly_d;
         collect_done_q <= collect_done_d;
      end
   end

   assign bus.sprite_on    = sprite_on_q;
   assign bus.rom_address  = rom_address_q;
   assign bus.blank_d      = blank_dly_q;
   assign bus.collect_done = collect_done_q;

endmodule

// File: tb/tb_coin_anim_addr.sv
// Scoreboard bench for coin_anim_addr: every driven cycle queues its expected registered outputs.
module tb_coin_anim_addr;

   logic vga_clk = 1'b0;
   logic reset   = 1'b1;

   coin_anim_addr_if ifc ();

   coin_anim_addr #(
      .SLOW_DIV      (6),
      .COLLECT_TICKS (16)
   ) dut (
      .vga_clk (vga_clk),
      .reset   (reset),
      .bus     (ifc)
   );

   always #5 vga_clk = ~vga_clk;

   int unsigned cyc = 0;
   always @(posedge vga_clk) cyc <= cyc + 1;

   typedef struct {
      int unsigned cyc;
      logic        on;
      logic [10:0] addr;
      logic        bd;
      logic        done;
      string       nm;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   function automatic int addr(input int dy, input int f, input int dx);
      return dy * 128 + f * 16 + dx;
   endfunction

   // One driven cycle; its outputs are due after the next rising edge.
   task automatic step(input int x, input int y, input logic b, input logic sp, input int sx,
                       input int sy, input logic co, input logic rs, input logic eon,
                       input int eaddr, input logic edone, input string nm);
      exp_t e;
      @(posedge vga_clk);
      #1;
      reset       = rs;
      ifc.DrawX   = 10'(x);
      ifc.DrawY   = 10'(y);
      ifc.blank   = b;
      ifc.spawn   = sp;
      ifc.spawn_x = 10'(sx);
      ifc.spawn_y = 10'(sy);
      ifc.collect = co;
      e.cyc  = cyc + 1;
      e.on   = eon;
      e.addr = 11'(eaddr);
      e.bd   = rs ? 1'b0 : b;
      e.done = edone;
      e.nm   = nm;
      sb.push_back(e);
   endtask

   task automatic pix(input int x, input int y, input logic b, input logic eon, input int eaddr,
                      input string nm);
      step(x, y, b, 1'b0, 0, 0, 1'b0, 1'b0, eon, eaddr, 1'b0, nm);
   endtask

   task automatic tick(input logic edone, input string nm);
      step(639, 479, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, edone, nm);
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge vga_clk);
         while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            n_tests++;
            if (e.cyc != cyc || ifc.sprite_on !== e.on || ifc.rom_address !== e.addr ||
                ifc.blank_d !== e.bd || ifc.collect_done !== e.done) begin
               n_fail++;
               $display("FAIL %s @cyc %0d: got on=%b addr=%0d bd=%b done=%b, want on=%b addr=%0d bd=%b done=%b",
                        e.nm, cyc, ifc.sprite_on, ifc.rom_address, ifc.blank_d,
                        ifc.collect_done, e.on, e.addr, e.bd, e.done);
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      ifc.DrawX = '0; ifc.DrawY = '0; ifc.blank = 1'b0; ifc.spawn = 1'b0;
      ifc.spawn_x = '0; ifc.spawn_y = '0; ifc.collect = 1'b0;

      repeat (3) step(0, 0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 0, 1'b0, "reset");
      for (int y = 0; y < 480; y += 40)
         for (int x = 0; x < 640; x += 50) pix(x, y, 1'b1, 1'b0, 0, "hidden_sweep");
      tick(1'b0, "hidden_tick");

      // Spawn mid-frame; nothing drawn until the frame commits.
      step(0, 0, 1'b0, 1'b1, 100, 200, 1'b0, 1'b0, 1'b0, 0, 1'b0, "spawn");
      pix(103, 205, 1'b1, 1'b0, 0, "pre_commit");
      tick(1'b0, "spin_tick");
      pix(103, 205, 1'b1, 1'b1, 643, "pix_643");
      pix(116, 205, 1'b1, 1'b0, 0, "right_out");
      pix(115, 215, 1'b1, 1'b1, addr(15, 0, 15), "corner_in");
      pix(99, 205, 1'b1, 1'b0, 0, "left_out");
      pix(103, 216, 1'b1, 1'b0, 0, "below_out");
      pix(103, 205, 1'b0, 1'b0, 0, "blanked");

      repeat (4) tick(1'b0, "spin_tick");
      pix(100, 200, 1'b1, 1'b1, 0, "spin_k5");
      tick(1'b0, "spin_tick");
      pix(100, 200, 1'b1, 1'b1, addr(0, 1, 0), "spin_k6");
      repeat (41) tick(1'b0, "spin_tick");
      pix(100, 200, 1'b1, 1'b1, addr(0, 7, 0), "spin_k47");
      tick(1'b0, "spin_tick");
      pix(100, 200, 1'b1, 1'b1, 0, "spin_wrap");

      // Collect wins over a simultaneous spawn.
      step(0, 0, 1'b0, 1'b1, 300, 300, 1'b1, 1'b0, 1'b0, 0, 1'b0, "collect_and_spawn");
      pix(100, 200, 1'b1, 1'b1, 0, "collect_start");
      pix(300, 300, 1'b1, 1'b0, 0, "spawn_ignored");
      tick(1'b0, "collect_tick");
      pix(100, 200, 1'b1, 1'b1, addr(0, 1, 0), "collect_t1");
      step(0, 0, 1'b0, 1'b1, 300, 300, 1'b1, 1'b0, 1'b0, 0, 1'b0, "collect_pulses_ignored");
      repeat (14) tick(1'b0, "collect_tick");
      pix(100, 200, 1'b1, 1'b1, addr(0, 7, 0), "collect_t15");
      tick(1'b1, "collect_done");
      pix(100, 200, 1'b1, 1'b0, 0, "gone_not_drawn");
      tick(1'b0, "gone_tick");

      // Out-of-range spawn clamps to the last full tile.
      step(0, 0, 1'b0, 1'b1, 700, 500, 1'b0, 1'b0, 1'b0, 0, 1'b0, "spawn_clamp");
      tick(1'b0, "clamp_tick");
      pix(624, 464, 1'b1, 1'b1, 0, "clamp_origin");
      pix(623, 464, 1'b1, 1'b0, 0, "clamp_left_out");
      pix(639, 479, 1'b1, 1'b1, addr(15, 0, 15), "clamp_corner");

      // Reset during collect must never produce collect_done.
      step(0, 0, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 0, 1'b0, "collect2");
      repeat (3) tick(1'b0, "collect2_tick");
      step(0, 0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 0, 1'b0, "reset_mid_collect");
      repeat (17) tick(1'b0, "post_reset_tick");
      pix(624, 464, 1'b1, 1'b0, 0, "post_reset_hidden");

      // Spawn on row 240: rest of this frame stays empty.
      pix(0, 239, 1'b1, 1'b0, 0, "row239");
      step(0, 240, 1'b1, 1'b1, 10, 250, 1'b0, 1'b0, 1'b0, 0, 1'b0, "spawn_row240");
      pix(12, 250, 1'b1, 1'b0, 0, "same_frame_row250");
      pix(25, 265, 1'b1, 1'b0, 0, "same_frame_row265");
      tick(1'b0, "midframe_tick");
      pix(12, 250, 1'b1, 1'b1, addr(0, 0, 2), "next_frame_row250");
      pix(25, 265, 1'b1, 1'b1, addr(15, 0, 15), "next_frame_row265");
      pix(10, 249, 1'b1, 1'b0, 0, "above_out");

      repeat (3) @(posedge vga_clk);
      @(negedge vga_clk);
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d entries left, want 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
